// File: rtl/cellular_automaton_pkg.sv
// Shared types and constants for the 1-D cellular automaton engine.
// Holds the FSM state enum, LFSR constants and the rule-table width helper.
package cellular_automaton_pkg;

   typedef enum logic [2:0] {
      ST_IDLE,
      ST_SEED,
      ST_RUN,
      ST_SWAP,
      ST_DONE
   } ca_state_t;

   // Galois taps for x^16+x^14+x^13+x^11+1, right-shifting form.
   localparam logic [15:0] LFSR_POLY         = 16'hB400;
   localparam logic [15:0] LFSR_DEFAULT_SEED = 16'hACE1;

   function automatic int rule_width(input int radius);
      return 1 << (2 * radius + 1);
   endfunction

endpackage

// File: rtl/cellular_automaton_if.sv
// Avalon-MM write-only port between the CA engine (master) and VRAM (slave).
// A beat transfers on a rising clock edge where vram_avn_write=1 and
// vram_avn_waitrequest=0; while stalled the master holds write/address/data.
interface cellular_automaton_if #(
   parameter int AVN_AW = 19,
   parameter int AVN_DW = 16
);
   logic              vram_avn_write;
   logic [AVN_AW-1:0] vram_avn_address;
   logic [AVN_DW-1:0] vram_avn_writedata;
   logic              vram_avn_waitrequest;

   modport master (
      output vram_avn_write,
      output vram_avn_address,
      output vram_avn_writedata,
      input  vram_avn_waitrequest
   );

   modport slave (
      input  vram_avn_write,
      input  vram_avn_address,
      input  vram_avn_writedata,
      output vram_avn_waitrequest
   );
endinterface

// File: rtl/cellular_automaton_lfsr16.sv
// 16-bit Galois LFSR used to seed a random first row; out is the current LSB.
// load wins over enable; a zero load value falls back to the default seed.
module ca_lfsr16
   import cellular_automaton_pkg::*;
(
   input  logic        clk,
   input  logic        rst,
   input  logic        load,
   input  logic [15:0] load_value,
   input  logic        enable,
   output logic        out
);

   logic [15:0] lfsr_q, lfsr_d;

   always_comb begin
      lfsr_d = lfsr_q;
      if (load) begin
         lfsr_d = (load_value == 16'h0000) ? LFSR_DEFAULT_SEED : load_value;
      end else if (enable) begin
         lfsr_d = {1'b0, lfsr_q[15:1]} ^ (lfsr_q[0] ? LFSR_POLY : 16'h0000);
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         lfsr_q <= LFSR_DEFAULT_SEED;
      end else begin
         lfsr_q <= lfsr_d;
      end
   end

   assign out = lfsr_q[0];

endmodule

// File: rtl/cellular_automaton_engine.sv
// 1-D cellular automaton generator writing one pixel per cell into VRAM.
// Ping-pong row buffers; one cell per accepted beat plus one SWAP cycle per row.
module cellular_automaton_engine
   import cellular_automaton_pkg::*;
#(
   parameter  int AVN_AW  = 19,
   parameter  int AVN_DW  = 16,
   parameter  int H_CELLS = 640,
   parameter  int V_ROWS  = 480,
   parameter  int RADIUS  = 1,
   localparam int RULE_W  = rule_width(RADIUS)
) (
   input  logic               sys_clk,
   input  logic               sys_rst,
   input  logic               start,
   input  logic               stop,
   input  logic [RULE_W-1:0]  ca_rule,
   input  logic               edge_mode,
   input  logic               seed_random,
   input  logic [15:0]        lfsr_seed,
   input  logic               continuous,
   input  logic [AVN_DW-1:0]  fg_color,
   input  logic [AVN_DW-1:0]  bg_color,
   cellular_automaton_if.master vram,
   output logic               busy,
   output logic               done,
   output logic [15:0]        generation,
   output ca_state_t          dbg_state
);

   localparam int COL_W = (H_CELLS > 1) ? $clog2(H_CELLS) : 1;
   localparam int ROW_W = (V_ROWS > 1) ? $clog2(V_ROWS) : 1;
   localparam int NB    = 2 * RADIUS + 1;

   ca_state_t           state_q, state_d;
   logic [H_CELLS-1:0]  buf0_q, buf0_d, buf1_q, buf1_d;
   logic                ptr_q, ptr_d;
   logic [COL_W-1:0]    col_q, col_d;
   logic [ROW_W-1:0]    row_q, row_d;
   logic [AVN_AW-1:0]   addr_cnt_q, addr_cnt_d;
   logic [15:0]         gen_q, gen_d;
   logic                stop_pend_q, stop_pend_d;
   logic [RULE_W-1:0]   rule_q, rule_d;
   logic                edge_q, edge_d, seed_rnd_q, seed_rnd_d, cont_q, cont_d;
   logic                write_q, write_d;
   logic [AVN_AW-1:0]   address_q, address_d;
   logic [AVN_DW-1:0]   wdata_q, wdata_d;
   logic                busy_q, busy_d, done_q, done_d;

   logic                lfsr_load, lfsr_en, lfsr_bit;
   logic [H_CELLS-1:0]  cur_buf;
   logic [NB-1:0]       nb_idx;
   int                  nb_pos;
   logic                nb_in;
   logic [COL_W-1:0]    nb_wrap;
   logic                next_cell, seed_cell, advance;

   ca_lfsr16 u_lfsr (
      .clk        (sys_clk),
      .rst        (sys_rst),
      .load       (lfsr_load),
      .load_value (lfsr_seed),
      .enable     (lfsr_en),
      .out        (lfsr_bit)
   );

   // Neighbourhood of the current column; leftmost neighbour is the index MSB.
   always_comb begin
      cur_buf = ptr_q ? buf1_q : buf0_q;
      nb_idx  = '0;
      nb_pos  = 0;
      nb_in   = 1'b0;
      nb_wrap = '0;
      for (int k = 0; k < NB; k++) begin
         nb_pos = int'(col_q) + k - RADIUS;
         nb_in  = (nb_pos >= 0) && (nb_pos < H_CELLS);
         if (nb_pos < 0) begin
            nb_wrap = COL_W'(nb_pos + H_CELLS);
         end else if (nb_pos >= H_CELLS) begin
            nb_wrap = COL_W'(nb_pos - H_CELLS);
         end else begin
            nb_wrap = COL_W'(nb_pos);
         end
         nb_idx[NB-1-k] = (nb_in || edge_q) ? cur_buf[nb_wrap] : 1'b0;
      end
      next_cell = rule_q[nb_idx];
   end

   always_comb begin
      state_d     = state_q;
      buf0_d      = buf0_q;
      buf1_d      = buf1_q;
      ptr_d       = ptr_q;
      col_d       = col_q;
      row_d       = row_q;
      addr_cnt_d  = addr_cnt_q;
      gen_d       = gen_q;
      stop_pend_d = stop_pend_q;
      rule_d      = rule_q;
      edge_d      = edge_q;
      seed_rnd_d  = seed_rnd_q;
      cont_d      = cont_q;
      write_d     = write_q;
      address_d   = address_q;
      wdata_d     = wdata_q;
      lfsr_load   = 1'b0;
      lfsr_en     = 1'b0;
      seed_cell   = seed_rnd_q ? lfsr_bit : (col_q == COL_W'(H_CELLS / 2));
      advance     = !write_q || !vram.vram_avn_waitrequest;

      if (stop && (state_q == ST_SEED || state_q == ST_RUN || state_q == ST_SWAP)) begin
         stop_pend_d = 1'b1;
      end

      case (state_q)
         ST_IDLE, ST_DONE: begin
            if (start) begin
               state_d     = ST_SEED;
               rule_d      = ca_rule;
               edge_d      = edge_mode;
               seed_rnd_d  = seed_random;
               cont_d      = continuous;
               col_d       = '0;
               row_d       = '0;
               addr_cnt_d  = '0;
               gen_d       = '0;
               stop_pend_d = 1'b0;
               lfsr_load   = 1'b1;
            end
         end
         ST_SEED: begin
            lfsr_en = 1'b1;
            if (ptr_q) buf1_d[col_q] = seed_cell;
            else       buf0_d[col_q] = seed_cell;
            if (col_q == COL_W'(H_CELLS - 1)) begin
               col_d   = '0;
               state_d = ST_RUN;
            end else begin
               col_d = col_q + 1'b1;
            end
         end
         ST_RUN: begin
            if (advance) begin
               write_d    = 1'b1;
               address_d  = addr_cnt_q;
               wdata_d    = cur_buf[col_q] ? fg_color : bg_color;
               addr_cnt_d = addr_cnt_q + 1'b1;
               if (ptr_q) buf0_d[col_q] = next_cell;
               else       buf1_d[col_q] = next_cell;
               if (col_q == COL_W'(H_CELLS - 1)) begin
                  col_d   = '0;
                  state_d = ST_SWAP;
               end else begin
                  col_d = col_q + 1'b1;
               end
            end
         end
         ST_SWAP: begin
            // Waits here until the row's last beat has left the output register.
            if (advance) begin
               write_d = 1'b0;
               ptr_d   = ~ptr_q;
               gen_d   = gen_q + 16'd1;
               row_d   = row_q + 1'b1;
               if (stop_pend_q) begin
                  state_d = ST_IDLE;
               end else if (row_q == ROW_W'(V_ROWS - 1)) begin
                  if (cont_q) begin
                     row_d      = '0;
                     addr_cnt_d = '0;
                     state_d    = ST_RUN;
                  end else begin
                     state_d = ST_DONE;
                  end
               end else begin
                  state_d = ST_RUN;
               end
            end
         end
         default: state_d = ST_IDLE;
      endcase

      busy_d = (state_d == ST_SEED) || (state_d == ST_RUN) || (state_d == ST_SWAP);
      done_d = (state_d == ST_DONE);
   end

   always_ff @(posedge sys_clk) begin
      if (sys_rst) begin
         state_q     <= ST_IDLE;
         buf0_q      <= '0;
         buf1_q      <= '0;
         ptr_q       <= 1'b0;
         col_q       <= '0;
         row_q       <= '0;
         addr_cnt_q  <= '0;
         gen_q       <= '0;
         stop_pend_q <= 1'b0;
         rule_q      <= '0;
         edge_q      <= 1'b0;
         seed_rnd_q  <= 1'b0;
         cont_q      <= 1'b0;
         write_q     <= 1'b0;
         address_q   <= '0;
         wdata_q     <= '0;
         busy_q      <= 1'b0;
         done_q      <= 1'b0;
      end else begin
         state_q     <= state_d;
         buf0_q      <= buf0_d;
         buf1_q      <= buf1_d;
         ptr_q       <= ptr_d;
         col_q       <= col_d;
         row_q       <= row_d;
         addr_cnt_q  <= addr_cnt_d;
         gen_q       <= gen_d;
         stop_pend_q <= stop_pend_d;
         rule_q      <= rule_d;
         edge_q      <= edge_d;
         seed_rnd_q  <= seed_rnd_d;
         cont_q      <= cont_d;
         write_q     <= write_d;
         address_q   <= address_d;
         wdata_q     <= wdata_d;
         busy_q      <= busy_d;
         done_q      <= done_d;
      end
   end

   assign vram.vram_avn_write     = write_q;
   assign vram.vram_avn_address   = address_q;
   assign vram.vram_avn_writedata = wdata_q;
   assign busy                    = busy_q;
   assign done                    = done_q;
   assign generation              = gen_q;
   assign dbg_state               = state_q;

endmodule

// File: tb/tb_cellular_automaton_engine.sv
// Bench for cellular_automaton_engine: an 8x4 screen with RADIUS=1 and RADIUS=2 builds.
// Expected VRAM beats are queued when a run is started and popped as beats are accepted.
module tb_cellular_automaton_engine;
   import cellular_automaton_pkg::*;

   localparam int AW = 19;
   localparam int DW = 16;
   localparam int H  = 8;
   localparam int V  = 4;
   localparam int W  = AW + DW;
   localparam logic [DW-1:0] FG = 16'hF00F;
   localparam logic [DW-1:0] BG = 16'h0A0A;
   localparam int ROW_CYC = H + 1;

   // ---------------- clock / reset ----------------
   logic clk = 1'b0;
   logic rst = 1'b1;
   logic rst2 = 1'b0;
   logic rst_any;
   int   cyc = 0;
   always #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;
   assign rst_any = rst | rst2;

   // ---------------- stimulus signals ----------------
   logic        start = 1'b0, stop = 1'b0, use2 = 1'b0, wreq = 1'b0;
   logic        start1, start2;
   logic        edge_mode = 1'b0, seed_random = 1'b0, continuous = 1'b0;
   logic [15:0] lfsr_seed = 16'h0000;
   logic [7:0]  ca_rule1 = 8'd0;
   logic [31:0] ca_rule2 = 32'd0;
   assign start1 = start & ~use2;
   assign start2 = start & use2;

   cellular_automaton_if #(.AVN_AW(AW), .AVN_DW(DW)) bus1 ();
   cellular_automaton_if #(.AVN_AW(AW), .AVN_DW(DW)) bus2 ();
   assign bus1.vram_avn_waitrequest = wreq;
   assign bus2.vram_avn_waitrequest = wreq;

   logic        busy1, done1, busy2, done2;
   logic [15:0] gen1, gen2;
   ca_state_t   st1, st2;

   cellular_automaton_engine #(
      .AVN_AW(AW), .AVN_DW(DW), .H_CELLS(H), .V_ROWS(V), .RADIUS(1)
   ) dut (
      .sys_clk(clk), .sys_rst(rst), .start(start1), .stop(stop),
      .ca_rule(ca_rule1), .edge_mode(edge_mode), .seed_random(seed_random),
      .lfsr_seed(lfsr_seed), .continuous(continuous),
      .fg_color(FG), .bg_color(BG), .vram(bus1.master),
      .busy(busy1), .done(done1), .generation(gen1), .dbg_state(st1)
   );

   cellular_automaton_engine #(
      .AVN_AW(AW), .AVN_DW(DW), .H_CELLS(H), .V_ROWS(V), .RADIUS(2)
   ) dut2 (
      .sys_clk(clk), .sys_rst(rst_any), .start(start2), .stop(stop),
      .ca_rule(ca_rule2), .edge_mode(edge_mode), .seed_random(seed_random),
      .lfsr_seed(lfsr_seed), .continuous(continuous),
      .fg_color(FG), .bg_color(BG), .vram(bus2.master),
      .busy(busy2), .done(done2), .generation(gen2), .dbg_state(st2)
   );

   logic          m_wr, m_busy, m_done;
   logic [AW-1:0] m_addr;
   logic [DW-1:0] m_data;
   logic [15:0]   m_gen;
   ca_state_t     m_state;
   assign m_wr    = use2 ? bus2.vram_avn_write     : bus1.vram_avn_write;
   assign m_addr  = use2 ? bus2.vram_avn_address   : bus1.vram_avn_address;
   assign m_data  = use2 ? bus2.vram_avn_writedata : bus1.vram_avn_writedata;
   assign m_busy  = use2 ? busy2 : busy1;
   assign m_done  = use2 ? done2 : done1;
   assign m_gen   = use2 ? gen2  : gen1;
   assign m_state = use2 ? st2   : st1;

   // ---------------- scoreboard ----------------
   logic [W-1:0]  exp_q[$];
   int            checks = 0, errors = 0;
   int            wr_cnt = 0, hold5 = 0, first_wr_cyc = -1, t0 = 0, run_cycles = 0;
   logic [AW-1:0] last_addr = '0;
   logic          have_last = 1'b0, wrap_seen = 1'b0, prev_stalled = 1'b0, stall_arm = 1'b0;
   logic [W-1:0]  prev_word = '0;

   task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s got=%0h exp=%0h (t=%0t)", tag, got, exp, $time);
      end
   endtask

   always @(negedge clk) begin
      logic [W-1:0] e;
      if (prev_stalled) begin
         check_eq("stall_write_held", m_wr, 1);
         check_eq("stall_beat_held", {m_addr, m_data}, prev_word);
      end
      if (m_wr) begin
         if (!use2 && m_addr == AW'(5)) hold5++;
         if (!wreq) begin
            if (wr_cnt == 0) first_wr_cyc = cyc;
            if (have_last && last_addr == AW'(H * V - 1) && m_addr == '0) begin
               check_eq("wrap_generation", m_gen, 4);
               check_eq("wrap_busy", m_busy, 1);
               wrap_seen = 1'b1;
            end
            check_eq("write_expected", exp_q.size() != 0, 1);
            if (exp_q.size() != 0) begin
               e = exp_q.pop_front();
               check_eq("write_beat", {m_addr, m_data}, e);
            end
            wr_cnt++;
            last_addr = m_addr;
            have_last = 1'b1;
         end
      end
      prev_stalled = m_wr && wreq;
      prev_word    = {m_addr, m_data};
   end

   // Stalls the slave for 3 cycles on the first beat to address 5 when armed.
   always @(posedge clk) begin
      #1;
      if (stall_arm && m_wr && m_addr == AW'(5)) begin
         stall_arm = 1'b0;
         wreq = 1'b1;
         repeat (3) @(posedge clk);
         #1;
         wreq = 1'b0;
      end
   end

   // ---------------- reference model ----------------
   function automatic logic [7:0] ca_step(input logic [31:0] rule, input int radius,
                                          input bit edg, input logic [7:0] cur);
      logic [7:0] nxt;
      int idx, p;
      bit v;
      nxt = '0;
      for (int c = 0; c < H; c++) begin
         idx = 0;
         for (int k = -radius; k <= radius; k++) begin
            p = c + k;
            if (p < 0 || p >= H) v = edg ? cur[(p + H) % H] : 1'b0;
            else                 v = cur[p];
            idx = (idx << 1) | int'(v);
         end
         nxt[c] = rule[idx];
      end
      return nxt;
   endfunction

   task automatic push_row(input int r, input logic [7:0] row);
      logic [W-1:0] e;
      for (int c = 0; c < H; c++) begin
         e = {AW'((r % V) * H + c), (row[c] ? FG : BG)};
         exp_q.push_back(e);
      end
   endtask

   task automatic push_rows(input logic [31:0] rule, input int radius, input bit edg,
                            input logic [7:0] seed, input int nrows);
      logic [7:0] row;
      row = seed;
      for (int r = 0; r < nrows; r++) begin
         push_row(r, row);
         row = ca_step(rule, radius, edg, row);
      end
   endtask

   // ---------------- driver tasks ----------------
   task automatic tick(input int n);
      repeat (n) begin
         @(posedge clk);
         #1;
      end
   endtask

   task automatic clear_run();
      wr_cnt = 0;
      hold5 = 0;
      first_wr_cyc = -1;
      have_last = 1'b0;
      wrap_seen = 1'b0;
   endtask

   task automatic pulse_start(input bit with_stop);
      start = 1'b1;
      stop  = with_stop;
      tick(1);
      start = 1'b0;
      stop  = 1'b0;
      t0    = cyc;
   endtask

   task automatic pulse_stop();
      stop = 1'b1;
      tick(1);
      stop = 1'b0;
   endtask

   task automatic wait_done(input int budget);
      for (int k = 0; k < budget && !m_done; k++) tick(1);
      run_cycles = cyc - t0;
      check_eq("done_reached", m_done, 1);
   endtask

   task automatic wait_idle(input int budget);
      for (int k = 0; k < budget && m_busy; k++) tick(1);
      check_eq("idle_reached", m_busy, 0);
   endtask

   task automatic wait_writes(input int n, input int budget);
      for (int k = 0; k < budget && wr_cnt < n; k++) tick(1);
      check_eq("writes_reached", wr_cnt >= n, 1);
   endtask

   // Rule 90 from a centre seed; bit i is column i.
   logic [7:0] r90_rows [4];

   // ---------------- test sequence ----------------
   initial begin
      r90_rows = '{8'b00010000, 8'b00101000, 8'b01000100, 8'b10101010};
      tick(3);
      rst = 1'b0;
      tick(1);

      check_eq("rst_write", bus1.vram_avn_write, 0);
      check_eq("rst_address", bus1.vram_avn_address, 0);
      check_eq("rst_writedata", bus1.vram_avn_writedata, 0);
      check_eq("rst_busy", busy1, 0);
      check_eq("rst_done", done1, 0);
      check_eq("rst_generation", gen1, 0);
      check_eq("rst_state", st1, ST_IDLE);
      check_eq("rst2_write", bus2.vram_avn_write, 0);
      check_eq("rst2_busy", busy2, 0);

      // Rule 90, centre seed, single pass; stop in the start cycle must be ignored.
      clear_run();
      for (int r = 0; r < V; r++) push_row(r, r90_rows[r]);
      ca_rule1 = 8'd90;
      pulse_start(1'b1);
      wait_done(200);
      check_eq("t1_runtime", run_cycles, H + V * ROW_CYC);
      check_eq("t1_first_write_lat", first_wr_cyc - t0, H + 1);
      check_eq("t1_writes", wr_cnt, H * V);
      check_eq("t1_queue_empty", exp_q.size(), 0);
      check_eq("t1_generation", gen1, 4);
      check_eq("t1_busy", busy1, 0);
      check_eq("t1_state", st1, ST_DONE);

      // Periodic edges, LFSR seed giving cell 7 only; restart from DONE, start mid-run ignored.
      clear_run();
      edge_mode = 1'b1;
      seed_random = 1'b1;
      lfsr_seed = 16'h0080;
      push_rows(32'd90, 1, 1'b1, 8'b1000_0000, V);
      pulse_start(1'b0);
      wait_writes(12, 100);
      pulse_start(1'b0);
      wait_done(200);
      check_eq("t2_writes", wr_cnt, H * V);
      check_eq("t2_queue_empty", exp_q.size(), 0);
      check_eq("t2_generation", gen1, 4);

      // lfsr_seed of zero falls back to 16'hACE1: first eight LSBs give 8'b1110_0001.
      clear_run();
      edge_mode = 1'b0;
      lfsr_seed = 16'h0000;
      ca_rule1 = 8'd30;
      push_rows(32'd30, 1, 1'b0, 8'b1110_0001, V);
      pulse_start(1'b0);
      wait_done(200);
      check_eq("t3_writes", wr_cnt, H * V);
      check_eq("t3_queue_empty", exp_q.size(), 0);

      // Three-cycle stall on address 5.
      clear_run();
      seed_random = 1'b0;
      ca_rule1 = 8'd90;
      for (int r = 0; r < V; r++) push_row(r, r90_rows[r]);
      stall_arm = 1'b1;
      pulse_start(1'b0);
      wait_done(200);
      check_eq("t4_runtime", run_cycles, H + V * ROW_CYC + 3);
      check_eq("t4_addr5_cycles", hold5, 4);
      check_eq("t4_queue_empty", exp_q.size(), 0);

      // Continuous mode wraps to address 0; stop during the wrapped row.
      clear_run();
      continuous = 1'b1;
      push_rows(32'd90, 1, 1'b0, 8'b0001_0000, V + 1);
      pulse_start(1'b0);
      wait_writes(H * V + 2, 200);
      pulse_stop();
      wait_idle(100);
      check_eq("t5_wrap_seen", wrap_seen, 1);
      check_eq("t5_writes", wr_cnt, H * (V + 1));
      check_eq("t5_done", done1, 0);
      check_eq("t5_state", st1, ST_IDLE);
      check_eq("t5_queue_empty", exp_q.size(), 0);
      continuous = 1'b0;

      // Stop mid-row 1: row completes through address 15, then silence.
      clear_run();
      push_row(0, r90_rows[0]);
      push_row(1, r90_rows[1]);
      pulse_start(1'b0);
      wait_writes(10, 100);
      pulse_stop();
      wait_idle(100);
      check_eq("t6_last_addr", last_addr, 15);
      check_eq("t6_done", done1, 0);
      check_eq("t6_busy", busy1, 0);
      tick(20);
      check_eq("t6_writes_after", wr_cnt, 2 * H);
      check_eq("t6_queue_empty", exp_q.size(), 0);

      // RADIUS=2 build, rule 32'h16, then reset in the middle of row 2.
      clear_run();
      use2 = 1'b1;
      ca_rule2 = 32'h0000_0016;
      push_rows(32'h0000_0016, 2, 1'b0, 8'b0001_0000, 3);
      pulse_start(1'b0);
      wait_writes(2 * H + 4, 200);
      rst2 = 1'b1;
      tick(1);
      check_eq("t7_rst_write", bus2.vram_avn_write, 0);
      check_eq("t7_rst_address", bus2.vram_avn_address, 0);
      check_eq("t7_rst_writedata", bus2.vram_avn_writedata, 0);
      check_eq("t7_rst_busy", busy2, 0);
      check_eq("t7_rst_done", done2, 0);
      check_eq("t7_rst_generation", gen2, 0);
      check_eq("t7_rst_state", st2, ST_IDLE);
      rst2 = 1'b0;
      exp_q.delete();
      tick(10);
      check_eq("t7_quiet_after_rst", bus2.vram_avn_write, 0);
      use2 = 1'b0;

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL watchdog expired at t=%0t", $time);
      $fatal(1, "watchdog");
   end

endmodule
